// File: rtl/l2_cache_control.sv
// L2 cache controller FSM: 4-way set-associative, pseudo-LRU replacement,
// write-back with victim writeback before fill. Outputs decode from state and inputs.
module l2_cache_control (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,
  output logic       pmem_read,
  output logic       pmem_write,
  input  logic       pmem_resp,
  input  logic [3:0] hit,
  input  logic [3:0] valid_o,
  input  logic [3:0] dirty_o,
  input  logic [2:0] MRU_o,
  output logic [2:0] MRU_i,
  output logic       load_MRU,
  output logic [3:0] valid_i,
  output logic [3:0] dirty_i,
  output logic       load_valid,
  output logic       load_dirty,
  output logic [3:0] load_tag,
  output logic [3:0] write_en_sel,
  output logic [3:0] data_i_sel,
  output logic [1:0] cacheline_o_sel,
  output logic       mm_address_sel
);

  typedef enum logic [2:0] {IDLE, CHECK, WB, FILL, SETTLE} state_t;
  state_t state;

  function automatic logic [1:0] victim_way(input logic [2:0] mru);
    if (!mru[2]) victim_way = mru[0] ? 2'd2 : 2'd3;
    else         victim_way = mru[1] ? 2'd0 : 2'd1;
  endfunction

  function automatic logic [2:0] plru_update(input logic [2:0] mru, input logic [1:0] way);
    plru_update = mru;
    case (way)
      2'd0:    begin plru_update[2] = 1'b0; plru_update[1] = 1'b0; end
      2'd1:    begin plru_update[2] = 1'b0; plru_update[1] = 1'b1; end
      2'd2:    begin plru_update[2] = 1'b1; plru_update[0] = 1'b0; end
      default: begin plru_update[2] = 1'b1; plru_update[0] = 1'b1; end
    endcase
  endfunction

  // Lowest-index way wins when the datapath reports several hits.
  function automatic logic [1:0] first_hit(input logic [3:0] h);
    if (h[0])      first_hit = 2'd0;
    else if (h[1]) first_hit = 2'd1;
    else if (h[2]) first_hit = 2'd2;
    else           first_hit = 2'd3;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] w);
    onehot = 4'b0001 << w;
  endfunction

  logic [1:0] victim;
  logic [1:0] hit_way;
  logic       any_hit;
  logic       victim_dirty;

  assign victim       = victim_way(MRU_o);
  assign hit_way      = first_hit(hit);
  assign any_hit      = |hit;
  assign victim_dirty = valid_o[victim] & dirty_o[victim];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (mem_read || mem_write) state <= CHECK;
        CHECK:   if (any_hit)           state <= IDLE;
                 else if (victim_dirty) state <= WB;
                 else                   state <= FILL;
        WB:      if (pmem_resp) state <= FILL;
        FILL:    if (pmem_resp) state <= SETTLE;
        SETTLE:  state <= CHECK;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    MRU_i           = 3'b000;
    load_MRU        = 1'b0;
    valid_i         = 4'b0000;
    dirty_i         = 4'b0000;
    load_valid      = 1'b0;
    load_dirty      = 1'b0;
    load_tag        = 4'b0000;
    write_en_sel    = 4'b0000;
    data_i_sel      = 4'b0000;
    cacheline_o_sel = 2'b00;
    mm_address_sel  = 1'b0;
    case (state)
      CHECK: begin
        if (any_hit) begin
          mem_resp = 1'b1;
          load_MRU = 1'b1;
          MRU_i    = plru_update(MRU_o, hit_way);
          // A simultaneous read+write request is serviced as a write.
          if (mem_write) begin
            write_en_sel = onehot(hit_way);
            load_dirty   = 1'b1;
            dirty_i      = dirty_o | onehot(hit_way);
          end else begin
            cacheline_o_sel = hit_way;
          end
        end
      end
      WB: begin
        pmem_write      = 1'b1;
        mm_address_sel  = 1'b1;
        cacheline_o_sel = victim;
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          write_en_sel = onehot(victim);
          data_i_sel   = onehot(victim);
          load_tag     = onehot(victim);
          load_valid   = 1'b1;
          valid_i      = valid_o | onehot(victim);
          load_dirty   = 1'b1;
          dirty_i      = dirty_o & ~onehot(victim);
        end
      end
      default: ;
    endcase
  end

endmodule
